// File: rtl/dram_pkg.sv
// Shared constants for the DRAM command controller: opcodes, FSM states and
// response error bit positions.
package dram_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_REFRESH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_WAIT,
        ST_REFRESH,
        ST_RESP
    } state_e;

    localparam int ERR_DRAM   = 0;
    localparam int ERR_PARITY = 1;

    // Bit 31 makes the stored 32-bit word even parity.
    function automatic logic [31:0] even_par_word(input logic [30:0] d);
        return {^d, d};
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer: saturating up-counter, temperature-selected
// threshold, and the pending flag that requests a refresh.
module dram_refresh_timer #(
    parameter int REF_INTERVAL = 64,
    parameter int TEMP_HOT     = 85
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic [7:0] temp_i,
    output logic       pending_o
);

    localparam int CW = $clog2(REF_INTERVAL + 1);
    localparam logic [CW-1:0] THR_NORM = CW'(REF_INTERVAL);
    localparam logic [CW-1:0] THR_HOT  = CW'(REF_INTERVAL / 2);
    localparam logic [7:0]    HOT_C    = 8'(TEMP_HOT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] thr;

    assign thr = (temp_i > HOT_C) ? THR_HOT : THR_NORM;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != THR_NORM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare is live each cycle, so a temperature rise takes effect at once.
    assign pending_o = (cnt_q >= thr);

endmodule

// File: rtl/dram_cmd_ctrl.sv
// Host-side DRAM command sequencer: one request at a time, timed opcode holds,
// write parity generation, read parity check and temperature-aware refresh.
module dram_cmd_ctrl #(
    parameter int WR_CYCLES    = 2,
    parameter int RD_LAT       = 1,
    parameter int REF_CYCLES   = 2,
    parameter int REF_INTERVAL = 64,
    parameter int TEMP_HOT     = 85
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [9:0]  req_row,
    input  logic [9:0]  req_col,
    input  logic [30:0] req_wdata,
    input  logic [7:0]  temp_in,
    output logic        rsp_valid,
    output logic [30:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [1:0]  dram_opcode,
    output logic [9:0]  dram_row,
    output logic [9:0]  dram_column,
    output logic [31:0] dram_data_in,
    output logic [7:0]  dram_temp,
    input  logic [31:0] dram_data_out,
    input  logic [1:0]  dram_error
);
    import dram_pkg::*;

    state_e      state_q;
    logic [7:0]  cyc_q;
    logic [1:0]  op_q;
    logic [9:0]  row_q;
    logic [9:0]  col_q;
    logic [31:0] din_q;
    logic [7:0]  temp_q;
    logic [30:0] rdata_q;
    logic [1:0]  err_q;
    logic        rsp_valid_q;
    logic [30:0] rsp_rdata_q;
    logic [1:0]  rsp_err_q;
    logic        ref_pending;
    logic        ref_clear;

    // The FSM leaves IDLE for REFRESH on exactly the cycle it sees pending.
    assign ref_clear = (state_q == ST_IDLE) && ref_pending;
    assign req_ready = (state_q == ST_IDLE) && !ref_pending;

    dram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .TEMP_HOT     (TEMP_HOT)
    ) u_ref_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (ref_clear),
        .temp_i    (temp_q),
        .pending_o (ref_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            op_q        <= OP_NOP;
            row_q       <= '0;
            col_q       <= '0;
            din_q       <= '0;
            temp_q      <= '0;
            rdata_q     <= '0;
            err_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
        end else begin
            temp_q      <= temp_in;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    op_q <= OP_NOP;
                    if (ref_pending) begin
                        state_q <= ST_REFRESH;
                        op_q    <= OP_REFRESH;
                        row_q   <= '0;
                        col_q   <= '0;
                        cyc_q   <= 8'(REF_CYCLES - 1);
                    end else if (req_valid) begin
                        row_q   <= req_row;
                        col_q   <= req_col;
                        rdata_q <= '0;
                        err_q   <= '0;
                        if (req_write) begin
                            state_q <= ST_WRITE;
                            op_q    <= OP_WRITE;
                            din_q   <= even_par_word(req_wdata);
                            cyc_q   <= 8'(WR_CYCLES - 1);
                        end else begin
                            state_q <= ST_READ;
                            op_q    <= OP_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (cyc_q == '0) begin
                        err_q[ERR_DRAM] <= |dram_error;
                        op_q            <= OP_NOP;
                        state_q         <= ST_RESP;
                    end else begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                ST_READ: begin
                    op_q    <= OP_NOP;
                    state_q <= ST_RD_WAIT;
                    cyc_q   <= 8'(RD_LAT - 1);
                end
                ST_RD_WAIT: begin
                    if (cyc_q == '0) begin
                        rdata_q           <= dram_data_out[30:0];
                        err_q[ERR_PARITY] <= ^dram_data_out;
                        err_q[ERR_DRAM]   <= |dram_error;
                        state_q           <= ST_RESP;
                    end else begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    op_q        <= OP_NOP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rdata_q;
                    rsp_err_q   <= err_q;
                    state_q     <= ST_IDLE;
                end
                ST_REFRESH: begin
                    if (cyc_q == '0) begin
                        op_q    <= OP_NOP;
                        state_q <= ST_IDLE;
                    end else begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                default: begin
                    op_q    <= OP_NOP;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dram_opcode  = op_q;
    assign dram_row     = row_q;
    assign dram_column  = col_q;
    assign dram_data_in = din_q;
    assign dram_temp    = temp_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_dram_cmd_ctrl.sv
// Scoreboard bench for dram_cmd_ctrl with a simple DRAM memory stub and a
// behavioural expectation model of host-visible results.
module tb_dram_cmd_ctrl;
    import dram_pkg::*;

    localparam int WR_CYCLES    = 2;
    localparam int RD_LAT       = 1;
    localparam int REF_CYCLES   = 2;
    localparam int REF_INTERVAL = 64;
    localparam int TEMP_HOT     = 85;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [9:0]  req_row, req_col;
    logic [30:0] req_wdata;
    logic [7:0]  temp_in;
    logic        rsp_valid;
    logic [30:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [1:0]  dram_opcode;
    logic [9:0]  dram_row, dram_column;
    logic [31:0] dram_data_in;
    logic [7:0]  dram_temp;
    logic [31:0] dram_data_out;
    logic [1:0]  dram_error;

    dram_cmd_ctrl #(
        .WR_CYCLES(WR_CYCLES), .RD_LAT(RD_LAT), .REF_CYCLES(REF_CYCLES),
        .REF_INTERVAL(REF_INTERVAL), .TEMP_HOT(TEMP_HOT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .temp_in(temp_in),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dram_opcode(dram_opcode), .dram_row(dram_row), .dram_column(dram_column),
        .dram_data_in(dram_data_in), .dram_temp(dram_temp),
        .dram_data_out(dram_data_out), .dram_error(dram_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DRAM stub: stores whatever the controller writes, returns it on read
    // with an optional bit-flip mask to provoke parity errors.
    logic [31:0] dmem [256];
    logic [31:0] rmem [256];
    logic [31:0] flip_mask = '0;
    logic [1:0]  err_drive = '0;
    initial for (int i = 0; i < 256; i++) begin dmem[i] = '0; rmem[i] = '0; end
    always @(posedge clk) if (dram_opcode == OP_WRITE) dmem[{dram_row[3:0], dram_column[3:0]}] <= dram_data_in;
    assign dram_data_out = dmem[{dram_row[3:0], dram_column[3:0]}] ^ flip_mask;
    assign dram_error    = err_drive;

    typedef struct {
        logic [30:0] rdata;
        logic [1:0]  err;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    logic [9:0]  exp_row, exp_col;
    logic [31:0] exp_din;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: response scoreboard plus opcode hold/address checks.
    logic [1:0] prev_op = OP_NOP;
    int run_len = 0;
    int ref_count = 0;
    int last_ref_start = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_op = OP_NOP;
            run_len = 0;
        end else begin
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: actual rsp_valid=1 rdata=%0h required no response", rsp_rdata);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            if (dram_opcode != prev_op) begin
                if (prev_op == OP_WRITE)   chk("write_hold", 64'(run_len), 64'(WR_CYCLES));
                if (prev_op == OP_REFRESH) chk("refresh_hold", 64'(run_len), 64'(REF_CYCLES));
                if (dram_opcode == OP_REFRESH) begin
                    ref_count++;
                    last_ref_start = cyc;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            if (dram_opcode == OP_WRITE) begin
                chk("write_data", 64'(dram_data_in), 64'(exp_din));
                chk("write_addr", 64'({dram_row, dram_column}), 64'({exp_row, exp_col}));
            end
            if (dram_opcode == OP_REFRESH)
                chk("refresh_addr", 64'({dram_row, dram_column}), 64'(0));
            prev_op = dram_opcode;
        end
    end

    task automatic set_req(input bit wr, input logic [9:0] row, input logic [9:0] col,
                           input logic [30:0] wd);
        req_valid = 1'b1; req_write = wr; req_row = row; req_col = col; req_wdata = wd;
        exp_row = row; exp_col = col; exp_din = {^wd, wd};
    endtask

    // Called at a negedge; returns the accept edge index in acc.
    task automatic do_req(input bit wr, input logic [9:0] row, input logic [9:0] col,
                          input logic [30:0] wd, input logic [1:0] e,
                          input logic [31:0] mask, output int acc);
        exp_t x;
        logic [31:0] w;
        logic [7:0] idx;
        int n;
        idx = {row[3:0], col[3:0]};
        set_req(wr, row, col, wd);
        err_drive = e;
        flip_mask = mask;
        n = 0;
        while (!req_ready && n < 400) begin @(negedge clk); n++; end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: actual req_ready=0 after %0d cycles required 1", n);
            req_valid = 1'b0; acc = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;
        if (wr) begin
            rmem[idx] = {^wd, wd};
            x.rdata = '0;
            x.err = {1'b0, |e};
            x.lat = WR_CYCLES + 1;
        end else begin
            w = rmem[idx] ^ mask;
            x.rdata = w[30:0];
            x.err = {^w, |e};
            x.lat = 1 + RD_LAT + 1;
        end
        x.acc = acc;
        sbq.push_back(x);
        n = 0;
        while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout: actual pending=%0d required 0", sbq.size());
            sbq.delete();
        end
        err_drive = '0;
        flip_mask = '0;
    endtask

    task automatic wait_ref_start(output int s);
        int c0, n;
        c0 = ref_count;
        n = 0;
        while (ref_count == c0 && n < 500) begin @(negedge clk); n++; end
        if (ref_count == c0) begin
            total++; bad++;
            $display("FAIL refresh_timeout: actual no REFRESH in %0d cycles required one", n);
        end
        s = last_ref_start;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, s1, s2, n;
        logic [31:0] mask;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_row = '0; req_col = '0; req_wdata = '0;
        temp_in = 8'd30;
        exp_row = '0; exp_col = '0; exp_din = '0;
        repeat (2) @(negedge clk);
        chk("reset_opcode", 64'(dram_opcode), 64'(OP_NOP));
        chk("reset_addr", 64'({dram_row, dram_column}), 64'(0));
        chk("reset_din", 64'(dram_data_in), 64'(0));
        chk("reset_temp", 64'(dram_temp), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_rdata, rsp_err}), 64'(0));
        chk("reset_ready", 64'(req_ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);
        chk("temp_copy", 64'(dram_temp), 64'(30));

        // Directed write / read / parity / error cases.
        do_req(1'b1, 10'd5, 10'd10, 31'h19973111, 2'b00, 32'h0, acc);
        chk("stored_word", 64'(dmem[{4'd5, 4'd10}]), 64'h99973111);
        do_req(1'b0, 10'd5, 10'd10, 31'h0, 2'b00, 32'h0, acc);
        do_req(1'b0, 10'd5, 10'd10, 31'h0, 2'b00, 32'h10000000, acc);
        do_req(1'b1, 10'd3, 10'd4, 31'h0000_0001, 2'b01, 32'h0, acc);
        do_req(1'b0, 10'd3, 10'd4, 31'h0, 2'b10, 32'h0, acc);

        // Refresh period at normal temperature and when hot.
        temp_in = 8'd30;
        wait_ref_start(s1);
        wait_ref_start(s1);
        wait_ref_start(s2);
        chk("ref_period_cold", 64'(s2 - s1), 64'(REF_INTERVAL + 1));
        temp_in = 8'd90;
        wait_ref_start(s1);
        wait_ref_start(s1);
        wait_ref_start(s2);
        chk("ref_period_hot", 64'(s2 - s1), 64'(REF_INTERVAL / 2 + 1));

        // Temperature rising past the hot point with the count already beyond it.
        temp_in = 8'd30;
        wait_ref_start(s1);
        wait_ref_start(s1);
        while (cyc < s1 + 40) @(negedge clk);
        temp_in = 8'd90;
        @(negedge clk);
        chk("temp_copy_hot", 64'(dram_temp), 64'(90));
        wait_ref_start(s2);
        chk("ref_on_temp_rise", 64'(s2 - s1), 64'(42));

        // Request held through the pending cycle: refresh goes first.
        temp_in = 8'd30;
        wait_ref_start(s1);
        wait_ref_start(s1);
        while (cyc < s1 + REF_INTERVAL) @(negedge clk);
        chk("ready_while_pending", 64'(req_ready), 64'(0));
        do_req(1'b0, 10'd5, 10'd10, 31'h0, 2'b00, 32'h0, acc);
        chk("accept_after_refresh", 64'(acc - s1), 64'(REF_INTERVAL + 1 + REF_CYCLES + 1));

        // Reset in the middle of a write.
        set_req(1'b1, 10'd9, 10'd9, 31'h1234567);
        n = 0;
        while (!req_ready && n < 400) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_write_op", 64'(dram_opcode), 64'(OP_WRITE));
        rst_n = 1'b0;
        #1;
        chk("reset_abort_op", 64'(dram_opcode), 64'(OP_NOP));
        chk("reset_abort_rsp", 64'(rsp_valid), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready), 64'(1));
        repeat (5) @(negedge clk);
        do_req(1'b1, 10'd9, 10'd9, 31'h7654321, 2'b00, 32'h0, acc);
        do_req(1'b0, 10'd9, 10'd9, 31'h0, 2'b00, 32'h0, acc);

        // Randomized traffic over a small address space.
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 0) temp_in = ($urandom_range(1) == 1) ? 8'd90 : 8'd30;
            mask = ($urandom_range(3) == 0) ? (32'h1 << $urandom_range(31)) : 32'h0;
            do_req(1'($urandom_range(1)), 10'($urandom_range(15)), 10'($urandom_range(15)),
                   31'($urandom), ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00,
                   mask, acc);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_cmd_ctrl.md
# dram_cmd_ctrl

Host-side command controller for the Micron DRAM model: the initiator that drives its opcode/row/column/data interface. Accepts one host request at a time over a valid/ready handshake, sequences the DRAM opcodes with the required hold times, and generates even parity on write data. It checks parity and the DRAM error code on completion and inserts temperature-dependent refreshes. Sits between the host request logic and the `Micron` instance.

## Interface
- `WR_CYCLES`, 2: cycles the WRITE opcode is held.
- `RD_LAT`, 1: cycles after the READ opcode cycle before `dram_data_out` is sampled (≥1).
- `REF_CYCLES`, 2: cycles the REFRESH opcode is held.
- `REF_INTERVAL`, 64: refresh period in cycles at normal temperature (even, ≥8).
- `TEMP_HOT`, 85: `temp_in` strictly above this halves the refresh period.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  host request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_row`  in  10  row address.
- `req_col`  in  10  column address.
- `req_wdata`  in  31  write payload.
- `temp_in`  in  8  die temperature, °C.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  31  read payload; 0 for writes.
- `rsp_err`  out  2  [0] DRAM reported error; [1] read-data parity fail.
- `dram_opcode`  out  2  00 NOP, 01 READ, 10 WRITE, 11 REFRESH.
- `dram_row`, `dram_column`  out  10 each  address to DRAM.
- `dram_data_in`  out  32  write word to DRAM.
- `dram_temp`  out  8  registered copy of `temp_in`.
- `dram_data_out`  in  32  read word from DRAM.
- `dram_error`  in  2  DRAM error code; nonzero = error.

## Operation
- FSM states: IDLE, WRITE, READ, RD_WAIT, REFRESH, RESP.
- `req_ready` = (state == IDLE) && !ref_pending. It is combinational from registered state only.
- Write word: `dram_data_in = {^req_wdata, req_wdata}`. Bit 31 makes the 32-bit word even parity (0x19973111 → 0x99973111). Row, column and data are latched at accept.
- IDLE: if ref_pending, go to REFRESH. Refresh wins over a simultaneous `req_valid`, and no accept occurs that cycle. Otherwise, on accept, go to WRITE or READ.
- WRITE: opcode 10 for `WR_CYCLES` cycles. On the last cycle, `dram_error` is sampled into err[0]. Next state is RESP.
- READ: opcode 01 for 1 cycle, then RD_WAIT with opcode 00 for `RD_LAT` cycles. On the last RD_WAIT cycle:
  - `dram_data_out` and `dram_error` are sampled;
  - err[1] = ^dram_data_out (odd parity);
  - rdata = dram_data_out[30:0].
- RESP: opcode 00, `rsp_valid`=1 for exactly one cycle with the sampled data/err, then IDLE.
- REFRESH: opcode 11, row/column 0, held `REF_CYCLES` cycles. Then IDLE, with no response.
- Refresh timer:
  - Counts every cycle and resets to 0 on entering REFRESH.
  - Threshold = `REF_INTERVAL`, or `REF_INTERVAL/2` when `dram_temp` > `TEMP_HOT`, evaluated each cycle.
  - Counter ≥ threshold sets ref_pending. If temperature rises past the threshold, pending asserts immediately.
  - Pending clears on entering REFRESH.
  - The counter saturates at `REF_INTERVAL` and never wraps.
- A request in progress is never pre-empted. Refresh waits until IDLE.

## Timing
- Reset (async assert) forces:
  - state IDLE;
  - `dram_opcode` 00, `dram_row`/`dram_column` 0, `dram_data_in` 0, `dram_temp` 0;
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0;
  - timer 0, ref_pending 0.
- Reset mid-operation aborts the operation with no response.
- All DRAM-side outputs are registered and change only on `clk` rising edges (except at reset).
- Write latency, accept edge to `rsp_valid` high: `WR_CYCLES`+1 cycles (3 default).
- Read latency: 1+`RD_LAT`+1 cycles (3 default).
- Throughput: a new accept is possible the cycle after RESP.

## Structure
- `dram_pkg` holds opcode constants (OP_NOP/READ/WRITE/REFRESH), the FSM state enum, and `rsp_err` bit indices. The testbench and `Micron` share these constants.
- Sub-module `dram_refresh_timer`: contains the counter, temperature threshold select and ref_pending. Inputs are a clear pulse and `dram_temp`.

## Test plan
- Write row 5, col 10, wdata 0x19973111 → `dram_opcode` 10 for 2 cycles, `dram_data_in` 0x99973111, `rsp_valid` 3 cycles after accept, `rsp_err` 00.
- Read row 5, col 10 with DRAM model returning 0x99973111 → `rsp_rdata` 0x19973111, `rsp_err` 00. Returning 0x89973111 → `rsp_err[1]`=1.
- `dram_error` forced 01 during the write's last cycle → `rsp_err` 01.
- `temp_in` 30: REFRESH every 64 cycles plus held durations. `temp_in` 90: the period drops to 32. `req_valid` held during the pending cycle → refresh first, and the request is accepted after it completes.
- `rst_n` low mid-WRITE → opcode 00 immediately, no `rsp_valid`. After release, `req_ready`=1 and a new request completes normally.
